fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Instruction-fetch front end directly upstream of the IF/ID pipeline register.
//  - Owns the PC and issues word fetches to instruction memory over a valid/ready request channel.
//  - Buffers in-order responses in a DEPTH-entry prefetch queue.
//  - Presents {instr, pc, pc+4} to IF/ID with a valid/ready handshake, so a hazard stall holds the head entry.
//  - Branch/jump redirects flush the queue and discard in-flight responses.
// PARAMETERS
//  ADDR_W   8      instruction address width; PC wraps modulo 2**ADDR_W
//  DATA_W   32     instruction word width
//  DEPTH    4      prefetch queue entries; also caps outstanding requests (power of 2, >=2)
//  PC_STEP  4      sequential PC increment
//  RESET_PC 0      PC loaded on reset
// PORTS
//  clk             in   1       single clock, rising edge
//  reset           in   1       asynchronous, active-low; 0 clears all state
//  redirect_valid  in   1       branch/jump taken this cycle
//  redirect_pc     in   ADDR_W  new fetch address
//  imem_req_valid  out  1       fetch request valid
//  imem_req_ready  in   1       instruction memory accepts request
//  imem_req_addr   out  ADDR_W  fetch address (current PC)
//  imem_rsp_valid  in   1       response word valid; responses in request order, >=1 cycle after accept
//  imem_rsp_data   in   DATA_W  instruction word
//  ifid_valid      out  1       head entry available to IF/ID
//  ifid_ready      in   1       IF/ID takes head (0 = hazard stall)
//  ifid_instr      out  DATA_W  head instruction
//  ifid_pc         out  ADDR_W  head instruction address
//  ifid_pc_plus4   out  ADDR_W  head address + PC_STEP, wrapped
// BEHAVIOUR
//  Reset (reset=0), asynchronous:
//   - pc=RESET_PC; queue empty; inflight=0; discard=0.
//   - imem_req_valid=0; ifid_valid=0; ifid_instr/pc/pc_plus4=0.
//  Issue: imem_req_valid = !redirect_valid && (inflight+count < DEPTH).
//   - On a req handshake, pc <= pc+PC_STEP (wraps) and inflight increments.
//   - First request is asserted in the first cycle after reset deasserts.
//  Response:
//   - When imem_rsp_valid, inflight decrements.
//   - If discard>0, the word is dropped and discard decrements; otherwise it is pushed with its PC.
//   - Each entry's PC comes from an internal request-order address FIFO.
//  Output:
//   - ifid_valid = (count>0) && !redirect_valid; fields are driven from the head entry.
//   - Pop on ifid_valid && ifid_ready.
//   - Latency: a response accepted in cycle N is visible at IF/ID in cycle N+1.
//  Simultaneous events:
//   - Push and pop in the same cycle leave count unchanged.
//   - Response and request handshakes in the same cycle leave inflight unchanged.
//   - Credit rule guarantees no overflow, so full queue + response cannot occur.
//  Redirect (highest priority):
//   - pc <= redirect_pc; queue and address FIFO flushed; no request issued; no pop.
//   - discard <= inflight minus any response arriving this cycle; that response is itself dropped.
//   - Back-to-back redirects are each honoured and discard is recomputed.
//  Errors:
//   - imem_rsp_valid with inflight==0 is ignored.
//   - Simulation assertion fires on that condition and on queue overflow.
//  Reset mid-operation: all state is cleared immediately; instruction memory must be reset on the same signal.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
//   - perf_stall_cnt counts cycles with ifid_valid && !ifid_ready.
//   - perf_flush_cnt counts redirect cycles.
//   - Both reset to 0 and saturate at all-ones.
//  FETCH_PERF_EN undefined: these ports and counters do not exist; behaviour otherwise identical.
// TESTING
//  1 Reset release, imem 1-cycle latency, ifid_ready=1:
//    -> req addrs 0,4,8,...; ifid_pc 0,4,8 on consecutive cycles; ifid_pc_plus4 = ifid_pc+4.
//  2 ifid_ready=0 for 10 cycles:
//    -> queue fills to DEPTH=4; imem_req_valid drops; head stays pc=0.
//    -> on release, pcs 0,4,8,12 drain in order with no gaps.
//  3 Two requests outstanding, imem latency 3, redirect_pc=0x40:
//    -> both late responses dropped; next ifid_pc=0x40; next req addr=0x40.
//  4 redirect_pc=0xFC, ifid_ready=1:
//    -> ifid_pc 0xFC then 0x00 (wrap); pc_plus4 for 0xFC is 0x00.
//  5 Reset driven low mid-stream with 3 entries queued:
//    -> ifid_valid=0 and imem_req_valid=0 in the same cycle; after release, fetch restarts at RESET_PC.
//  6 FETCH_PERF_EN: 5 stall cycles + 2 redirects -> perf_stall_cnt=5, perf_flush_cnt=2.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
// Instruction-fetch front end feeding the IF/ID pipeline register.
// Owns the PC and issues word fetches over a valid/ready request channel.
// In-order responses are buffered in a DEPTH-entry prefetch queue.
// The queue head is presented to IF/ID as {instr, pc, pc+PC_STEP}.
// Redirects flush the queue and drop every response still in flight.
// Optional feature: define FETCH_PERF_EN to add the saturating performance
// counters perf_stall_cnt and perf_flush_cnt.
module fetch_prefetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              ifid_valid,
    input  logic              ifid_ready,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [CNT_W:0]    DEPTH_W = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);

    // Fetch PC and outstanding-request bookkeeping
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  inflight;   // requests accepted, response not yet seen
    logic [CNT_W-1:0]  discard;    // of those, how many belong to a flushed path

    // Prefetch queue: instruction word plus its fetch address
    logic [DATA_W-1:0] q_instr [DEPTH];
    logic [ADDR_W-1:0] q_pc    [DEPTH];
    logic [PTR_W-1:0]  q_wr_ptr;
    logic [PTR_W-1:0]  q_rd_ptr;
    logic [CNT_W-1:0]  count;

    // Request-order address FIFO: holds addresses of live outstanding requests
    logic [ADDR_W-1:0] a_mem [DEPTH];
    logic [PTR_W-1:0]  a_wr_ptr;
    logic [PTR_W-1:0]  a_rd_ptr;

    logic credit_ok;
    logic req_fire;
    logic rsp_fire;
    logic push;
    logic pop;
    logic has_head;

    // Credit covers both queued entries and responses still on their way,
    // so a full queue can never receive a response.
    assign credit_ok      = ({1'b0, inflight} + {1'b0, count}) < DEPTH_W;
    assign imem_req_valid = reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is stray and is ignored entirely.
    assign rsp_fire = imem_rsp_valid && (inflight != '0);
    // Responses of a flushed path, or arriving during a redirect, are dropped.
    assign push     = rsp_fire && !redirect_valid && (discard == '0);

    assign has_head      = (count != '0);
    assign ifid_valid    = has_head && !redirect_valid;
    assign pop           = ifid_valid && ifid_ready;
    assign ifid_instr    = has_head ? q_instr[q_rd_ptr] : '0;
    assign ifid_pc       = has_head ? q_pc[q_rd_ptr] : '0;
    assign ifid_pc_plus4 = has_head ? q_pc[q_rd_ptr] + STEP : '0;

    // PC register: redirect wins, otherwise advance on each accepted request
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (req_fire) begin
            pc <= pc + STEP;
        end
    end

    // Outstanding-request count and number of stale responses to drop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
            discard  <= '0;
        end else begin
            case ({req_fire, rsp_fire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (redirect_valid) begin
                // Everything still in flight after this cycle is stale.
                discard <= inflight - CNT_W'(rsp_fire);
            end else if (rsp_fire && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
        end
    end

    // Address FIFO pointers: write on request, read when a response is kept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_wr_ptr <= '0;
            a_rd_ptr <= '0;
        end else if (redirect_valid) begin
            a_wr_ptr <= '0;
            a_rd_ptr <= '0;
        end else begin
            if (req_fire) begin
                a_wr_ptr <= a_wr_ptr + 1'b1;
            end
            if (push) begin
                a_rd_ptr <= a_rd_ptr + 1'b1;
            end
        end
    end

    // Address FIFO storage: remember the address of each accepted request
    // NOTE: storage arrays are not reset; the pointers and counters already
    // mark which slots hold valid data, so clearing the contents adds nothing.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            a_mem[a_wr_ptr] <= pc;
        end
    end

    // Prefetch queue pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                q_wr_ptr <= q_wr_ptr + 1'b1;
            end
            if (pop) begin
                q_rd_ptr <= q_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Prefetch queue storage: pair each kept word with its request address
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[q_wr_ptr] <= imem_rsp_data;
            q_pc[q_wr_ptr]    <= a_mem[a_rd_ptr];
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters for hazard-stall cycles and redirect cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (ifid_valid && !ifid_ready && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            end
            if (redirect_valid && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            end
        end
    end
`endif

    // Protocol checks: stray responses and queue overflow must never happen
    assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (inflight != '0));
    assert property (@(posedge clk) disable iff (!reset)
        push |-> (count != FULL));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit
// Self-checking bench for fetch_prefetch_unit. An instruction-memory model
// answers in order after a configurable latency; a transaction-level model
// (queues of requests and queued instructions) predicts every output each
// cycle. Directed scenarios add explicit checks of their key outcomes.
module tb_fetch_prefetch_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              imem_req_valid;
    logic              imem_req_ready = 1'b0;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid = 1'b0;
    logic [DATA_W-1:0] imem_rsp_data = '0;
    logic              ifid_valid;
    logic              ifid_ready = 1'b0;
    logic [DATA_W-1:0] ifid_instr;
    logic [ADDR_W-1:0] ifid_pc;
    logic [ADDR_W-1:0] ifid_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_flush_cnt;
`endif

    fetch_prefetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .ifid_valid     (ifid_valid),
        .ifid_ready     (ifid_ready),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus4  (ifid_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One memory request as seen on the bus; live clears when a redirect
    // makes its eventual response stale.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
        bit                live;
    } req_t;

    // One instruction expected in the prefetch queue
    typedef struct {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    req_t              pend[$];
    ent_t              fq[$];
    logic [ADDR_W-1:0] exp_pc;
    int                cyc = 0;
    int                last_due = -1;
    int                lat_min = 1;
    int                lat_max = 1;
    int                n_checks = 0;
    int                n_fail = 0;

    // Outputs sampled mid-cycle by the most recent step()
    logic              s_req_valid;
    logic [ADDR_W-1:0] s_req_addr;
    logic              s_ifid_valid;
    logic [ADDR_W-1:0] s_ifid_pc;
    logic [ADDR_W-1:0] s_ifid_pc4;

    // Distinctive instruction word derived from its address
    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return {8'hA5, a, ~a, a ^ 8'h3C};
    endfunction

    // One clock cycle: drive the memory response, compare every output with
    // the model, then advance the model across the rising edge.
    // Entered and left at a falling edge.
    task automatic step();
        logic              exp_req_valid;
        logic              exp_ifid_valid;
        logic              rsp_now;
        logic [DATA_W-1:0] rsp_word;
        logic [ADDR_W-1:0] exp_pc4;
        int                lat;
        req_t              r;
        ent_t              e;

        rsp_now  = (pend.size() > 0) && (pend[0].due <= cyc);
        rsp_word = rsp_now ? word_of(pend[0].addr) : DATA_W'($urandom());
        // NOTE: bench inputs are driven with blocking assignments away from the
        // active edge, so the DUT sees settled values at the next rising edge.
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_word;
        #1;

        exp_req_valid  = !redirect_valid && ((pend.size() + fq.size()) < DEPTH);
        exp_ifid_valid = (fq.size() > 0) && !redirect_valid;

        n_checks++;
        if (imem_req_valid !== exp_req_valid) begin
            n_fail++;
            $display("FAIL req_valid cyc %0d: got %b want %b", cyc, imem_req_valid, exp_req_valid);
        end
        if (exp_req_valid) begin
            n_checks++;
            if (imem_req_addr !== exp_pc) begin
                n_fail++;
                $display("FAIL req_addr cyc %0d: got %h want %h", cyc, imem_req_addr, exp_pc);
            end
        end
        n_checks++;
        if (ifid_valid !== exp_ifid_valid) begin
            n_fail++;
            $display("FAIL ifid_valid cyc %0d: got %b want %b", cyc, ifid_valid, exp_ifid_valid);
        end
        if (exp_ifid_valid) begin
            exp_pc4 = fq[0].pc + 8'd4;
            n_checks++;
            if ({ifid_instr, ifid_pc, ifid_pc_plus4} !== {fq[0].instr, fq[0].pc, exp_pc4}) begin
                n_fail++;
                $display("FAIL ifid_fields cyc %0d: got %h/%h/%h want %h/%h/%h", cyc,
                         ifid_instr, ifid_pc, ifid_pc_plus4, fq[0].instr, fq[0].pc, exp_pc4);
            end
        end

        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_ifid_valid = ifid_valid;
        s_ifid_pc    = ifid_pc;
        s_ifid_pc4   = ifid_pc_plus4;

        @(posedge clk);
        if (exp_ifid_valid && ifid_ready) begin
            e = fq.pop_front();
        end
        if (rsp_now) begin
            r = pend.pop_front();
            if (r.live && !redirect_valid) begin
                e.instr = rsp_word;
                e.pc    = r.addr;
                fq.push_back(e);
            end
        end
        if (redirect_valid) begin
            fq.delete();
            foreach (pend[i]) pend[i].live = 1'b0;
            exp_pc = redirect_pc;
        end else if (exp_req_valid && imem_req_ready) begin
            exp_pc = exp_pc + 8'd4;
        end
        // The memory accepts whatever the DUT actually put on the bus.
        if (s_req_valid && imem_req_ready) begin
            lat    = int'($urandom_range(lat_max, lat_min));
            r.addr = s_req_addr;
            r.live = 1'b1;
            r.due  = cyc + lat;
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            pend.push_back(r);
        end
        cyc++;
        @(negedge clk);
    endtask

    // Hold reset for two cycles, clear the model and memory, then release
    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        ifid_ready     = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend.delete();
        fq.delete();
        exp_pc   = 8'h00;
        last_due = -1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        n_checks++;
        if ({imem_req_valid, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req_valid=%b ifid_valid=%b instr=%h pc=%h pc4=%h want all zero",
                     imem_req_valid, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4);
        end
        do_reset();
    endtask

    task automatic test_basic_stream();
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;
        step();
        n_checks++;
        if ({s_req_valid, s_req_addr} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL first_req: got %b/%h want 1/00", s_req_valid, s_req_addr);
        end
        step();
        n_checks++;
        if ({s_req_valid, s_req_addr} !== {1'b1, 8'h04}) begin
            n_fail++;
            $display("FAIL second_req: got %b/%h want 1/04", s_req_valid, s_req_addr);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({s_ifid_valid, s_ifid_pc, s_ifid_pc4} !== {1'b1, 8'(4 * i), 8'(4 * i + 4)}) begin
                n_fail++;
                $display("FAIL stream_pc[%0d]: got %b/%h/%h want 1/%h/%h", i,
                         s_ifid_valid, s_ifid_pc, s_ifid_pc4, 8'(4 * i), 8'(4 * i + 4));
            end
        end
        repeat (20) step();
    endtask

    task automatic test_stall_fill();
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b0;
        repeat (10) step();
        n_checks++;
        if ({s_req_valid, s_ifid_valid, s_ifid_pc} !== {1'b0, 1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL stall_full: got req_valid=%b ifid_valid=%b pc=%h want 0/1/00",
                     s_req_valid, s_ifid_valid, s_ifid_pc);
        end
        ifid_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({s_ifid_valid, s_ifid_pc} !== {1'b1, 8'(4 * i)}) begin
                n_fail++;
                $display("FAIL drain_pc[%0d]: got %b/%h want 1/%h", i, s_ifid_valid, s_ifid_pc, 8'(4 * i));
            end
        end
        repeat (10) step();
    endtask

    task automatic test_redirect_inflight();
        bit found;
        do_reset();
        lat_min = 3; lat_max = 3;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        step();
        redirect_valid = 1'b0;
        step();
        n_checks++;
        if ({s_req_valid, s_req_addr} !== {1'b1, 8'h40}) begin
            n_fail++;
            $display("FAIL redirect_req: got %b/%h want 1/40", s_req_valid, s_req_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = s_ifid_valid;
        end
        n_checks++;
        if (!found || s_ifid_pc !== 8'h40) begin
            n_fail++;
            $display("FAIL redirect_first_pc: got found=%b pc=%h want 1/40", found, s_ifid_pc);
        end
        repeat (10) step();
    endtask

    task automatic test_wrap();
        bit found;
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFC;
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = s_ifid_valid;
        end
        n_checks++;
        if (!found || {s_ifid_pc, s_ifid_pc4} !== {8'hFC, 8'h00}) begin
            n_fail++;
            $display("FAIL wrap_head: got found=%b pc=%h pc4=%h want 1/fc/00", found, s_ifid_pc, s_ifid_pc4);
        end
        step();
        n_checks++;
        if ({s_ifid_valid, s_ifid_pc, s_ifid_pc4} !== {1'b1, 8'h00, 8'h04}) begin
            n_fail++;
            $display("FAIL wrap_next: got %b/%h/%h want 1/00/04", s_ifid_valid, s_ifid_pc, s_ifid_pc4);
        end
        repeat (5) step();
    endtask

    task automatic test_back_to_back();
        bit found;
        do_reset();
        lat_min = 2; lat_max = 2;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        step();
        redirect_pc    = 8'h20;
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = s_ifid_valid;
        end
        n_checks++;
        if (!found || s_ifid_pc !== 8'h20) begin
            n_fail++;
            $display("FAIL back_to_back_pc: got found=%b pc=%h want 1/20", found, s_ifid_pc);
        end
        repeat (5) step();
    endtask

    task automatic test_reset_midstream();
        int guard;
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b0;
        guard = 0;
        while (fq.size() != 3 && guard < 20) begin
            step();
            guard++;
        end
        n_checks++;
        if (fq.size() != 3) begin
            n_fail++;
            $display("FAIL midreset_fill: got %0d queued want 3", fq.size());
        end
        #1;
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if ({imem_req_valid, ifid_valid, ifid_pc} !== {1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b/%b/%h want 0/0/00", imem_req_valid, ifid_valid, ifid_pc);
        end
        pend.delete();
        fq.delete();
        exp_pc   = 8'h00;
        last_due = -1;
        @(negedge clk);
        reset      = 1'b1;
        ifid_ready = 1'b1;
        step();
        n_checks++;
        if ({s_req_valid, s_req_addr} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL midreset_restart: got %b/%h want 1/00", s_req_valid, s_req_addr);
        end
        repeat (10) step();
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        int guard;
        do_reset();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;
        guard = 0;
        while (fq.size() == 0 && guard < 20) begin
            step();
            guard++;
        end
        ifid_ready = 1'b0;
        repeat (5) step();
        ifid_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h10;
        step();
        step();
        redirect_valid = 1'b0;
        n_checks++;
        if ({perf_stall_cnt, perf_flush_cnt} !== {32'd5, 32'd2}) begin
            n_fail++;
            $display("FAIL perf_counts: got stall=%0d flush=%0d want 5/2", perf_stall_cnt, perf_flush_cnt);
        end
        repeat (5) step();
    endtask
`endif

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            ifid_ready     = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = ADDR_W'($urandom());
            step();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        ifid_ready     = 1'b1;
        repeat (30) step();
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_stall_fill();
        test_redirect_inflight();
        test_wrap();
        test_back_to_back();
        test_reset_midstream();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so a stuck run still terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
